// File: rtl/obstacle_scheduler.sv
// Obstacle sequencer for the runner game: spawns, moves, retires and scores N obstacle slots.
// Latency: every output is registered; a movement tick shows up on the cycle after the tick cycle.
// Backpressure: none; spawns wait for a free slot, and collision freezes everything in OVER.
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   game_en           level: high runs the game, low returns to IDLE
//   collision         level: player hit an obstacle (ignored outside RUN)
//   speed_lvl         pixels per tick minus one, sampled on tick cycles
//   obst_xpos         slot i x position at [12*i+11 : 12*i]
//   obst_valid        slot i is active
//   game_over         high while in OVER
//   score             obstacles retired since the game started, saturating
module obstacle_scheduler #(
  parameter int N_OBST   = 3,
  parameter int TICK_DIV = 4_000_000,
  parameter int SPAWN_X  = 750,
  parameter int MIN_GAP  = 40
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 game_en,
  input  logic                 collision,
  input  logic [1:0]           speed_lvl,
  output logic [12*N_OBST-1:0] obst_xpos,
  output logic [N_OBST-1:0]    obst_valid,
  output logic                 game_over,
  output logic [15:0]          score
);

  localparam int            TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OVER = 2'd2;

  logic [1:0]        state;
  logic [TW-1:0]     tick_cnt;
  logic [7:0]        lfsr;
  logic [7:0]        gap_cnt;
  logic [7:0]        gap_target;
  logic [11:0]       xpos_q [N_OBST];
  logic [N_OBST-1:0] valid_q;

  logic              tick;
  logic              do_clear;
  logic              run_go;
  logic [11:0]       step;
  logic [N_OBST-1:0] retire;
  logic [N_OBST-1:0] spawn_sel;
  logic              spawn;
  logic [2:0]        retire_cnt;
  logic [16:0]       score_sum;
  logic [15:0]       score_next;

  always_comb begin
    tick      = (state == S_RUN) && (tick_cnt == TICK_LAST);
    // Leaving RUN/OVER for IDLE clears in the same edge, so IDLE is never seen with stale slots.
    do_clear  = (state == S_IDLE) ||
                ((state == S_RUN) && !collision && !game_en) ||
                ((state == S_OVER) && !game_en);
    // A tick coinciding with collision is dropped: OVER keeps the pre-tick picture.
    run_go    = (state == S_RUN) && !collision && game_en;
    step      = 12'(speed_lvl) + 12'd1;
    retire     = '0;
    spawn_sel  = '0;
    retire_cnt = '0;
    for (int i = 0; i < N_OBST; i++) begin
      // Checking xpos <= step before subtracting keeps the position from wrapping below zero.
      retire[i]  = valid_q[i] && (xpos_q[i] <= step);
      retire_cnt = retire_cnt + 3'(retire[i]);
    end
    // Free slots are judged on the pre-tick valid flags, so a slot retiring this tick
    // cannot be refilled until the next one. Descending scan leaves the lowest index selected.
    for (int i = N_OBST - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        spawn_sel    = '0;
        spawn_sel[i] = 1'b1;
      end
    end
    spawn      = (gap_cnt >= gap_target) && (|spawn_sel);
    score_sum  = {1'b0, score} + 17'(retire_cnt);
    score_next = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_comb begin
    obst_xpos = '0;
    for (int i = 0; i < N_OBST; i++) begin
      obst_xpos[12*i +: 12] = xpos_q[i];
    end
    obst_valid = valid_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      tick_cnt   <= '0;
      lfsr       <= 8'hA5;
      gap_cnt    <= '0;
      gap_target <= 8'(MIN_GAP);
      valid_q    <= '0;
      for (int i = 0; i < N_OBST; i++) xpos_q[i] <= '0;
      game_over  <= 1'b0;
      score      <= '0;
    end else begin
      // x^8+x^6+x^5+x^4+1, shift-left Fibonacci; maximal length so it never locks at zero.
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

      case (state)
        S_IDLE: begin
          if (game_en) begin
            state   <= S_RUN;
            // Preloading the gap makes the first spawn land on the first tick.
            gap_cnt <= gap_target;
          end
        end
        S_RUN: begin
          if (collision) begin
            state     <= S_OVER;
            game_over <= 1'b1;
          end else if (!game_en) begin
            state <= S_IDLE;
          end
        end
        S_OVER: begin
          if (!game_en) begin
            state     <= S_IDLE;
            game_over <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (do_clear) begin
        valid_q  <= '0;
        for (int i = 0; i < N_OBST; i++) xpos_q[i] <= '0;
        score    <= '0;
        tick_cnt <= '0;
      end else if (run_go) begin
        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        if (tick) begin
          for (int i = 0; i < N_OBST; i++) begin
            if (spawn && spawn_sel[i]) begin
              xpos_q[i]  <= 12'(SPAWN_X);
              valid_q[i] <= 1'b1;
            end else if (retire[i]) begin
              xpos_q[i]  <= '0;
              valid_q[i] <= 1'b0;
            end else if (valid_q[i]) begin
              xpos_q[i] <= xpos_q[i] - step;
            end
          end
          score <= score_next;
          if (spawn) begin
            gap_cnt    <= '0;
            gap_target <= 8'(MIN_GAP) + {2'b00, lfsr[5:0]};
          end else if (gap_cnt != 8'hFF) begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/obstacle_scheduler.md
# obstacle_scheduler

Multi-slot obstacle sequencer for the VGA runner game. It owns N horizontal obstacle slots and spawns them at the right screen edge after pseudo-random gaps. It moves them left at a tick rate scaled by a speed level, retires them at the left edge and counts them into a score. It stops everything on collision. Per-slot positions and valid flags go to the obstacle drawing blocks; collision comes from the hit-detection logic.

## Interface
- N_OBST, 3, number of obstacle slots (1..4)
- TICK_DIV, 4_000_000, clk cycles per movement tick
- SPAWN_X, 750, x position loaded on spawn (12-bit)
- MIN_GAP, 40, minimum ticks between spawns

- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- game_en  in  1  level; high = game running, low = return to IDLE
- collision  in  1  level; player hit an obstacle
- speed_lvl  in  2  pixels moved per tick = speed_lvl + 1
- obst_xpos  out  12*N_OBST  slot i at bits [12*i+11 : 12*i]
- obst_valid  out  N_OBST  slot i is active and must be drawn
- game_over  out  1  high while in OVER
- score  out  16  obstacles retired since the game started; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, RUN, OVER.
- IDLE
  - All slots are cleared: xpos 0, valid 0.
  - score = 0, tick counter = 0.
  - Transition: game_en = 1 -> RUN.
  - On entry to RUN, gap_cnt is loaded with gap_target, so the first spawn happens on the first tick.
- RUN
  - Tick counter counts 0..TICK_DIV-1 and wraps. A tick occurs on the cycle where the count equals TICK_DIV-1.
  - Each tick, with step = speed_lvl + 1, for every valid slot:
    - if xpos <= step: retire the slot (valid 0, xpos 0) and add 1 to score;
    - else: xpos -= step.
  - Several slots retiring on the same tick add their count to score in one update. The score add saturates.
  - Spawn, evaluated on each tick:
    - Condition: gap_cnt >= gap_target and at least one slot was free at the start of that tick.
    - Action: the lowest-index free slot gets xpos = SPAWN_X, valid = 1. gap_cnt is cleared, and gap_target reloads to MIN_GAP + lfsr[5:0].
    - A slot retiring on a tick is not reusable until the next tick.
  - gap_cnt increments on each tick that has no spawn and saturates at 8'hFF.
  - If no slot is free, the spawn is deferred; it fires on the first tick where a slot is free.
  - collision = 1 -> OVER. collision has priority over game_en.
  - game_en = 0 (and no collision) -> IDLE.
- OVER
  - Positions, valid flags and score are frozen. The tick counter stops.
  - game_over = 1.
  - game_en = 0 -> IDLE.
- LFSR
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1.
  - Loads 8'hA5 on reset and steps every clk cycle in every state.
  - It never reaches 0.
- speed_lvl is sampled on the tick cycle only.

## Timing
- All outputs are registered. Effects of a tick are visible on the cycle after the tick cycle.
- Reset values: obst_xpos all 0, obst_valid 0, game_over 0, score 0. FSM = IDLE, tick counter 0, gap_target = MIN_GAP.
- State change is registered: one cycle after the input condition.
- game_over rises one cycle after collision is sampled in RUN, and falls one cycle after game_en = 0 is sampled in OVER.
- Reset mid-game clears everything asynchronously. The first RUN after reset uses gap_target = MIN_GAP.
- collision in IDLE is ignored. collision while already in OVER has no further effect.
- If a tick and collision occur on the same cycle, the tick's movement is not applied; OVER freezes the pre-tick values.
- Subtraction is 12-bit unsigned. The xpos <= step check prevents wrap-around below 0.

## Test plan
- Reset and idle: assert rst with game_en = 0 -> all outputs 0 and state IDLE. After release, outputs stay 0 for 100 cycles.
- First spawn and movement (TICK_DIV = 4, speed_lvl = 0): raise game_en.
  - One cycle after the first tick: slot 0 has valid 1, xpos 750.
  - After 10 further ticks: xpos 740.
  - With speed_lvl = 3: each tick subtracts 4.
- Retire and score (SPAWN_X = 8, speed_lvl = 1):
  - Slot 0 goes 8 -> 6 -> 4 -> 2, then retires on the next tick: valid 0, xpos 0, score 1.
  - No underflow value ever appears on obst_xpos.
- Slot exhaustion (MIN_GAP = 0, large SPAWN_X):
  - Slots 0, 1, 2 fill on consecutive spawn ticks, then spawns defer.
  - When a slot retires, it is refilled on the next tick, not the retiring tick.
- Collision: pulse collision mid-RUN.
  - game_over = 1 next cycle; positions and score are unchanged for 1000 cycles.
  - Drop game_en -> game_over 0 and all slots cleared one cycle later.
- Abort and restart: drop game_en in RUN -> IDLE with everything cleared. Raise it again -> the score restarts at 0 and the first spawn lands on the first tick.
